// File: rtl/jump_offset_encoder.sv
// jump_offset_encoder
//   Reverse lookup for relative-jump offsets. It holds a writable table of
//   N signed D-bit offsets. A query searches the table one entry per cycle
//   and returns the lowest index whose valid entry equals the query offset,
//   or reports a miss.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   wr_en     table write strobe (accepted in any FSM state)
//   wr_addr   table entry to write
//   wr_data   offset to store; the write also marks the entry valid
//   q_valid   query request
//   q_ready   block can accept a query (IDLE only)
//   q_offset  offset to search for, captured on acceptance
//   r_valid   result available (RESP)
//   r_ready   consumer accepts the result
//   r_hit     1 = match found, 0 = miss
//   r_index   lowest matching index, 0 on miss
//   busy      FSM is not in IDLE
module jump_offset_encoder #(
  parameter int D  = 12,
  parameter int AW = 6,
  parameter int N  = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [D-1:0]  wr_data,
  input  logic          q_valid,
  output logic          q_ready,
  input  logic [D-1:0]  q_offset,
  output logic          r_valid,
  input  logic          r_ready,
  output logic          r_hit,
  output logic [AW-1:0] r_index,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t          state;
  state_t          state_next;
  logic [D-1:0]    tbl_data [N];
  logic [N-1:0]    tbl_vld;
  logic [D-1:0]    key;
  logic [AW-1:0]   idx;
  logic            armed;
  logic            hit_reg;
  logic [AW-1:0]   index_reg;
  logic            entry_match;

  // The first SCAN cycle only arms the comparator, so entry k is examined
  // in the (k+1)-th cycle after acceptance and a hit at k is reported k+2
  // cycles after acceptance. The compare reads the table as it stands in
  // that cycle, so a write landing on the same edge that ends the compare
  // is not seen.
  assign entry_match = armed && tbl_vld[idx] && (tbl_data[idx] == key);

  // Offset table: a write stores the data and marks the entry valid.
  // Reset empties the whole table, so nothing matches until it is reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) begin
        tbl_data[j] <= '0;
      end
      tbl_vld <= '0;
    end else if (wr_en) begin
      tbl_data[wr_addr] <= wr_data;
      tbl_vld[wr_addr]  <= 1'b1;
    end
  end

  // Next-state logic. A query is accepted only in IDLE. SCAN ends on the
  // first match or after the last entry. RESP waits for the consumer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (q_valid) state_next = SCAN;
      SCAN: if (armed && (entry_match || idx == LAST)) state_next = RESP;
      RESP: if (r_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and scan datapath. The key is captured at acceptance,
  // so later changes on q_offset do not matter. The index stops at the last
  // entry and never wraps. The result registers stay frozen through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key       <= '0;
      idx       <= '0;
      armed     <= 1'b0;
      hit_reg   <= 1'b0;
      index_reg <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (q_valid) begin
            key   <= q_offset;
            idx   <= '0;
            armed <= 1'b0;
          end
        end
        SCAN: begin
          if (!armed) begin
            armed <= 1'b1;
          end else if (entry_match) begin
            hit_reg   <= 1'b1;
            index_reg <= idx;
          end else if (idx == LAST) begin
            hit_reg   <= 1'b0;
            index_reg <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RESP: begin
          if (r_ready) begin
            hit_reg   <= 1'b0;
            index_reg <= '0;
            armed     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake and status outputs are decoded directly from the state.
  assign q_ready = (state == IDLE);
  assign r_valid = (state == RESP);
  assign busy    = (state != IDLE);
  assign r_hit   = hit_reg;
  assign r_index = index_reg;

endmodule

// File: tb/tb_jump_offset_encoder.sv
// tb_jump_offset_encoder
//   Directed bench for jump_offset_encoder. Inputs are driven 1 ns after a
//   rising edge and outputs are sampled at the same point. Latency is
//   counted in rising edges from the acceptance edge to the first edge
//   after which r_valid is high.
module tb_jump_offset_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        q_valid = 1'b0;
  logic        q_ready;
  logic [11:0] q_offset = '0;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic        r_hit;
  logic [5:0]  r_index;
  logic        busy;

  int tests_run = 0;
  int failed = 0;
  int cyc = 0;
  int acc_cyc = 0;

  logic       got;
  logic       hit_obs;
  logic [5:0] idx_obs;
  int         lat_obs;

  jump_offset_encoder #(.D(12), .AW(6), .N(64)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .q_valid(q_valid), .q_ready(q_ready),
    .q_offset(q_offset), .r_valid(r_valid), .r_ready(r_ready),
    .r_hit(r_hit), .r_index(r_index), .busy(busy)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used to measure query latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic write_entry(input logic [5:0] addr, input logic [11:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic start_query(input logic [11:0] off);
    q_valid = 1'b1; q_offset = off;
    @(posedge clk); #1;
    q_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_result();
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(posedge clk); #1;
      if (r_valid) got = 1'b1;
    end
    hit_obs = r_hit;
    idx_obs = r_index;
    lat_obs = cyc - acc_cyc;
  endtask

  task automatic finish_resp();
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests_run++; if (q_ready !== 1'b1) begin failed++; $display("[TB] FAIL reset_q_ready: got %b expected 1", q_ready); end
    tests_run++; if (r_valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_r_valid: got %b expected 0", r_valid); end
    tests_run++; if (r_hit !== 1'b0) begin failed++; $display("[TB] FAIL reset_r_hit: got %b expected 0", r_hit); end
    tests_run++; if (r_index !== 6'd0) begin failed++; $display("[TB] FAIL reset_r_index: got %0d expected 0", r_index); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    start_query(12'd0);
    wait_result();
    tests_run++; if (got !== 1'b1) begin failed++; $display("[TB] FAIL empty_timeout: got %b expected 1", got); end
    tests_run++; if (hit_obs !== 1'b0) begin failed++; $display("[TB] FAIL empty_hit: got %b expected 0", hit_obs); end
    tests_run++; if (idx_obs !== 6'd0) begin failed++; $display("[TB] FAIL empty_index: got %0d expected 0", idx_obs); end
    tests_run++; if (lat_obs != 65) begin failed++; $display("[TB] FAIL empty_latency: got %0d expected 65", lat_obs); end
    finish_resp();
  endtask

  task automatic test_load_and_hit();
    int vals [9] = '{-66, 73, -10, 59, 8, 4, -84, 7, 6};
    for (int i = 0; i < 9; i++) write_entry(6'(i), 12'(vals[i]));
    start_query(12'd59);
    wait_result();
    tests_run++; if (got !== 1'b1) begin failed++; $display("[TB] FAIL hit59_timeout: got %b expected 1", got); end
    tests_run++; if (hit_obs !== 1'b1) begin failed++; $display("[TB] FAIL hit59_hit: got %b expected 1", hit_obs); end
    tests_run++; if (idx_obs !== 6'd3) begin failed++; $display("[TB] FAIL hit59_index: got %0d expected 3", idx_obs); end
    tests_run++; if (lat_obs != 5) begin failed++; $display("[TB] FAIL hit59_latency: got %0d expected 5", lat_obs); end
    finish_resp();
    start_query(12'hFAC);
    wait_result();
    tests_run++; if (hit_obs !== 1'b1) begin failed++; $display("[TB] FAIL hitm84_hit: got %b expected 1", hit_obs); end
    tests_run++; if (idx_obs !== 6'd6) begin failed++; $display("[TB] FAIL hitm84_index: got %0d expected 6", idx_obs); end
    tests_run++; if (lat_obs != 8) begin failed++; $display("[TB] FAIL hitm84_latency: got %0d expected 8", lat_obs); end
    finish_resp();
  endtask

  task automatic test_stability();
    start_query(12'd73);
    q_offset = 12'd8;
    wait_result();
    tests_run++; if (idx_obs !== 6'd1) begin failed++; $display("[TB] FAIL stable_index: got %0d expected 1", idx_obs); end
    tests_run++; if (lat_obs != 3) begin failed++; $display("[TB] FAIL stable_latency: got %0d expected 3", lat_obs); end
    finish_resp();
  endtask

  task automatic test_priority();
    write_entry(6'd5, 12'd4);
    write_entry(6'd20, 12'd4);
    start_query(12'd4);
    wait_result();
    tests_run++; if (idx_obs !== 6'd5) begin failed++; $display("[TB] FAIL prio_index: got %0d expected 5", idx_obs); end
    tests_run++; if (lat_obs != 7) begin failed++; $display("[TB] FAIL prio_latency: got %0d expected 7", lat_obs); end
    finish_resp();
    write_entry(6'd5, 12'd9);
    start_query(12'd4);
    wait_result();
    tests_run++; if (hit_obs !== 1'b1) begin failed++; $display("[TB] FAIL prio2_hit: got %b expected 1", hit_obs); end
    tests_run++; if (idx_obs !== 6'd20) begin failed++; $display("[TB] FAIL prio2_index: got %0d expected 20", idx_obs); end
    tests_run++; if (lat_obs != 22) begin failed++; $display("[TB] FAIL prio2_latency: got %0d expected 22", lat_obs); end
    finish_resp();
  endtask

  task automatic test_resp_hold();
    start_query(12'hFAC);
    wait_result();
    for (int c = 0; c < 10; c++) begin
      q_valid  = (c == 4);
      q_offset = 12'd8;
      @(posedge clk); #1;
      tests_run++; if (r_valid !== 1'b1) begin failed++; $display("[TB] FAIL hold_r_valid c=%0d: got %b expected 1", c, r_valid); end
      tests_run++; if (r_hit !== 1'b1) begin failed++; $display("[TB] FAIL hold_r_hit c=%0d: got %b expected 1", c, r_hit); end
      tests_run++; if (r_index !== 6'd6) begin failed++; $display("[TB] FAIL hold_r_index c=%0d: got %0d expected 6", c, r_index); end
      tests_run++; if (q_ready !== 1'b0) begin failed++; $display("[TB] FAIL hold_q_ready c=%0d: got %b expected 0", c, q_ready); end
    end
    q_valid = 1'b0;
    finish_resp();
    tests_run++; if (q_ready !== 1'b1) begin failed++; $display("[TB] FAIL release_q_ready: got %b expected 1", q_ready); end
    tests_run++; if (r_valid !== 1'b0) begin failed++; $display("[TB] FAIL release_r_valid: got %b expected 0", r_valid); end
    @(posedge clk); #1;
    tests_run++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL ignored_query_busy: got %b expected 0", busy); end
  endtask

  task automatic test_write_during_scan();
    start_query(12'd99);
    repeat (10) @(posedge clk);
    #1;
    write_entry(6'd3, 12'd99);
    write_entry(6'd40, 12'd99);
    wait_result();
    tests_run++; if (hit_obs !== 1'b1) begin failed++; $display("[TB] FAIL midwr_hit: got %b expected 1", hit_obs); end
    tests_run++; if (idx_obs !== 6'd40) begin failed++; $display("[TB] FAIL midwr_index: got %0d expected 40", idx_obs); end
    tests_run++; if (lat_obs != 42) begin failed++; $display("[TB] FAIL midwr_latency: got %0d expected 42", lat_obs); end
    finish_resp();
  endtask

  task automatic test_reset_mid_scan();
    start_query(12'd7);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (q_ready !== 1'b1) begin failed++; $display("[TB] FAIL midrst_q_ready: got %b expected 1", q_ready); end
    tests_run++; if (r_valid !== 1'b0) begin failed++; $display("[TB] FAIL midrst_r_valid: got %b expected 0", r_valid); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    tests_run++; if (r_hit !== 1'b0) begin failed++; $display("[TB] FAIL midrst_r_hit: got %b expected 0", r_hit); end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (r_valid !== 1'b0) begin failed++; $display("[TB] FAIL postrst_r_valid: got %b expected 0", r_valid); end
    start_query(12'd7);
    wait_result();
    tests_run++; if (hit_obs !== 1'b0) begin failed++; $display("[TB] FAIL postrst_hit: got %b expected 0", hit_obs); end
    tests_run++; if (idx_obs !== 6'd0) begin failed++; $display("[TB] FAIL postrst_index: got %0d expected 0", idx_obs); end
    tests_run++; if (lat_obs != 65) begin failed++; $display("[TB] FAIL postrst_latency: got %0d expected 65", lat_obs); end
    finish_resp();
  endtask

  initial begin
    test_reset();
    test_load_and_hit();
    test_stability();
    test_priority();
    test_resp_hold();
    test_write_during_scan();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
